// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for an RV32I subset
// (lw, sw, R-type, I-type ALU, beq, jal) on a shared regfile/ALU datapath.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   op, funct3, funct7b5 instruction fields (IR[6:0], IR[14:12], IR[30])
//   Zero                ALU zero flag (beq)
//   mem_ready           memory completes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl        datapath mux/ALU controls
//   instr_done          one-cycle retire pulse
//   illegal             one-cycle pulse in DECODE for an unsupported opcode
//   retired_cnt, illegal_cnt  wrapping debug counters
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  // Ungated enables; the ports below are masked by rst_n so nothing can
  // write while reset is asserted, even if a Mealy input is high.
  logic pc_write, mem_write, ir_write, reg_write, done, ill;
  logic [2:0] alu_dec;

  always_comb begin
    unique case (funct3)
      3'b000:  alu_dec = (state_q == S_EXECR && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    done       = 1'b0;
    ill        = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;

    unique case (state_q)
      S_FETCH: begin
        ResultSrc = 2'b10;
        ALUSrcB   = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BEQ;
          7'b1101111:             state_d = S_JAL;
          default: begin
            ill     = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        pc_write   = Zero;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (done) retired_cnt_d = retired_cnt_q + CNT_W'(1);
    if (ill)  illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      retired_cnt_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      retired_cnt_q <= retired_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign PCWrite     = pc_write  & rst_n;
  assign MemWrite    = mem_write & rst_n;
  assign IRWrite     = ir_write  & rst_n;
  assign RegWrite    = reg_write & rst_n;
  assign instr_done  = done      & rst_n;
  assign illegal     = ill       & rst_n;
  assign retired_cnt = retired_cnt_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: steps one cycle at a time and checks
// the control bundle against hand-written per-state expectations. Fields the
// design leaves unspecified in a state are masked out of that comparison.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, Zero, mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ALUControl;
  logic [31:0] retired_cnt, illegal_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .instr_done(instr_done), .illegal(illegal),
    .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
  );

  // Bundle: [15]PCWrite [14]AdrSrc [13]MemWrite [12]IRWrite [11]RegWrite
  //         [10:9]ResultSrc [8:7]ALUSrcA [6:5]ALUSrcB [4:2]ALUControl
  //         [1]instr_done [0]illegal
  wire [15:0] bundle = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                        ALUSrcA, ALUSrcB, ALUControl, instr_done, illegal};

  localparam logic [15:0] M_EN  = 16'hB803;
  localparam logic [15:0] M_ADR = 16'h4000;
  localparam logic [15:0] M_RES = 16'h0600;
  localparam logic [15:0] M_ALU = 16'h01FC;
  localparam logic [15:0] M_ALL = 16'hFFFF;

  function automatic logic [15:0] mk(logic pcw, logic adr, logic mw, logic irw,
                                     logic rw, logic [1:0] res, logic [1:0] sa,
                                     logic [1:0] sb, logic [2:0] alu,
                                     logic dn, logic il);
    return {pcw, adr, mw, irw, rw, res, sa, sb, alu, dn, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Check the bundle mid-cycle, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [15:0] exp, input logic [15:0] mask);
    @(negedge clk);
    chk(tag, {16'h0, bundle & mask}, {16'h0, exp & mask});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0;
    mem_ready = 1'b1;

    // Reset held 3 cycles with mem_ready high: enables forced low, FETCH selects.
    for (int i = 0; i < 3; i++)
      cyc("reset", mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    chk("reset_retired", retired_cnt, 0);
    chk("reset_illegal", illegal_cnt, 0);

    rst_n = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      cyc("idle_fetch", mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    chk("idle_retired", retired_cnt, 0);

    // add then sub (R-type)
    mem_ready = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    cyc("add_fetch",  mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    cyc("add_decode", mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0), M_EN|M_ALU);
    cyc("add_execr",  mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,0,0), M_EN|M_ALU);
    cyc("add_aluwb",  mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,1,0), M_EN|M_RES);
    funct7b5 = 1'b1;
    cyc("sub_fetch",  mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    cyc("sub_decode", mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0), M_EN|M_ALU);
    cyc("sub_execr",  mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,0,0), M_EN|M_ALU);
    cyc("sub_aluwb",  mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,1,0), M_EN|M_RES);
    chk("rtype_retired", retired_cnt, 2);

    // addi with funct7b5 = 1 must still add; ori; R-type and/slt
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    cyc("addi_fetch", mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    cyc("addi_decode",mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0), M_EN|M_ALU);
    cyc("addi_execi", mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0), M_EN|M_ALU);
    cyc("addi_aluwb", mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,1,0), M_EN|M_RES);
    funct3 = 3'b110; funct7b5 = 1'b0;
    cyc("ori_fetch",  mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    cyc("ori_decode", mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0), M_EN|M_ALU);
    cyc("ori_execi",  mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b011,0,0), M_EN|M_ALU);
    cyc("ori_aluwb",  mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,1,0), M_EN|M_RES);
    op = 7'b0110011; funct3 = 3'b111;
    cyc("and_fetch",  mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    cyc("and_decode", mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0), M_EN|M_ALU);
    cyc("and_execr",  mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b010,0,0), M_EN|M_ALU);
    cyc("and_aluwb",  mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,1,0), M_EN|M_RES);
    funct3 = 3'b010;
    cyc("slt_fetch",  mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    cyc("slt_decode", mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0), M_EN|M_ALU);
    cyc("slt_execr",  mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b101,0,0), M_EN|M_ALU);
    cyc("slt_aluwb",  mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,1,0), M_EN|M_RES);
    chk("alu_retired", retired_cnt, 6);

    // lw with two stall cycles in MEMREAD (7 cycles total)
    op = 7'b0000011; funct3 = 3'b010;
    cyc("lw_fetch",   mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    cyc("lw_decode",  mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0), M_EN|M_ALU);
    cyc("lw_memadr",  mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0), M_EN|M_ALU);
    mem_ready = 1'b0;
    cyc("lw_memrd0",  mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0), M_EN|M_ADR|M_RES);
    cyc("lw_memrd1",  mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0), M_EN|M_ADR|M_RES);
    mem_ready = 1'b1;
    cyc("lw_memrd2",  mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0), M_EN|M_ADR|M_RES);
    cyc("lw_memwb",   mk(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,1,0), M_EN|M_RES);
    chk("lw_retired", retired_cnt, 7);

    // sw with one stall cycle: MemWrite two cycles, retire on the second
    op = 7'b0100011;
    cyc("sw_fetch",   mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    cyc("sw_decode",  mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0), M_EN|M_ALU);
    cyc("sw_memadr",  mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0), M_EN|M_ALU);
    mem_ready = 1'b0;
    cyc("sw_memwr0",  mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,0,0), M_EN|M_ADR|M_RES);
    mem_ready = 1'b1;
    cyc("sw_memwr1",  mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,1,0), M_EN|M_ADR|M_RES);
    chk("sw_retired", retired_cnt, 8);

    // beq taken / not taken
    op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1;
    cyc("beq1_fetch", mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    cyc("beq1_decode",mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0), M_EN|M_ALU);
    cyc("beq1_beq",   mk(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,1,0), M_EN|M_ALU|M_RES);
    Zero = 1'b0;
    cyc("beq0_fetch", mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    cyc("beq0_decode",mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0), M_EN|M_ALU);
    cyc("beq0_beq",   mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,1,0), M_EN|M_ALU|M_RES);
    chk("beq_retired", retired_cnt, 10);

    // jal
    op = 7'b1101111;
    cyc("jal_fetch",  mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    cyc("jal_decode", mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0), M_EN|M_ALU);
    cyc("jal_jal",    mk(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,0,0), M_EN|M_ALU|M_RES);
    cyc("jal_aluwb",  mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,1,0), M_EN|M_RES);
    chk("jal_retired", retired_cnt, 11);

    // illegal opcode
    op = 7'b0000000;
    cyc("ill_fetch",  mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    cyc("ill_decode", mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,1), M_EN|M_ALU);
    chk("ill_cnt", illegal_cnt, 1);
    chk("ill_retired", retired_cnt, 11);
    mem_ready = 1'b0;
    cyc("ill_back_fetch", mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);

    // async reset during a stalled MEMWRITE
    mem_ready = 1'b1; op = 7'b0100011;
    cyc("rst_fetch",  mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    cyc("rst_decode", mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0), M_EN|M_ALU);
    cyc("rst_memadr", mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0), M_EN|M_ALU);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_memwr_before", {31'h0, MemWrite}, 1);
    #1 rst_n = 1'b0;
    #0;
    #1 chk("rst_memwr_async", {31'h0, MemWrite}, 0);
    chk("rst_bundle_async", {16'h0, bundle}, {16'h0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,0)});
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("rst_after_fetch", mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,0), M_ALL);
    chk("rst_after_retired", retired_cnt, 0);
    chk("rst_after_illegal", illegal_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
